// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: load-use stall, multi-cycle multiply hold, branch squash.
// Macro PIPELINE_CTRL_MULT_STALL_EN enables the multi-cycle multiply (MULT state).
module pipeline_ctrl #(
    parameter int MULT_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_regA,
    input  logic [4:0]  id_regB,
    input  logic        id_useA,
    input  logic        id_useB,
    input  logic        id_mult,
    input  logic        id_jump_or_branch,
    input  logic [4:0]  ex_write_reg,
    input  logic        ex_mem_read,
    output logic        lock_if,
    output logic        lock_id,
    output logic        lock_ex,
    output logic        bubble_ex,
    output logic        bubble_mem,
    output logic        squash_id,
    output logic [1:0]  state,
    output logic [15:0] stall_cycles
);
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MULT    = 2'd1,
        FLUSH   = 2'd2,
        ILLEGAL = 2'd3
    } state_t;

    state_t st;
    logic   hazard;
    logic   a_hit, b_hit;

    assign state = st;

    // Gated by rst_n so the combinational stall path stays quiet during reset.
    always_comb begin
        a_hit  = id_useA && (id_regA == ex_write_reg);
        b_hit  = id_useB && (id_regB == ex_write_reg);
        hazard = rst_n && (st == RUN) && ex_mem_read && (ex_write_reg != 5'd0) && (a_hit || b_hit);
    end

    always_comb begin
        lock_if    = 1'b0;
        lock_id    = 1'b0;
        lock_ex    = 1'b0;
        bubble_ex  = 1'b0;
        bubble_mem = 1'b0;
        squash_id  = 1'b0;
        case (st)
            RUN: begin
                lock_if   = hazard;
                lock_id   = hazard;
                bubble_ex = hazard;
            end
            MULT: begin
                lock_if    = 1'b1;
                lock_id    = 1'b1;
                lock_ex    = 1'b1;
                bubble_mem = 1'b1;
            end
            FLUSH:   squash_id = 1'b1;
            default: ;
        endcase
    end

`ifdef PIPELINE_CTRL_MULT_STALL_EN
    logic [4:0] cnt;

    // Counter loads MULT_LAT-2 so MULT lasts MULT_LAT-1 cycles after the RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st  <= RUN;
            cnt <= 5'd0;
        end else begin
            case (st)
                RUN: begin
                    if (!hazard) begin
                        if (id_mult) begin
                            st  <= MULT;
                            cnt <= 5'(MULT_LAT - 2);
                        end else if (id_jump_or_branch) begin
                            st <= FLUSH;
                        end
                    end
                end
                MULT: begin
                    if (cnt == 5'd0) st <= RUN;
                    else             cnt <= cnt - 5'd1;
                end
                FLUSH:   st <= RUN;
                default: st <= RUN;
            endcase
        end
    end
`else
    logic unused_mult;
    assign unused_mult = id_mult ^ (MULT_LAT > 16);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= RUN;
        end else begin
            case (st)
                RUN:     if (!hazard && id_jump_or_branch) st <= FLUSH;
                default: st <= RUN;
            endcase
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  stall_cycles <= 16'd0;
        else if (lock_if && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed cases, random traffic, counter saturation.
module tb_pipeline_ctrl;
    localparam int ML = 4;
`ifdef PIPELINE_CTRL_MULT_STALL_EN
    localparam bit MULT_EN = 1'b1;
`else
    localparam bit MULT_EN = 1'b0;
`endif

    logic        clk, rst_n;
    logic [4:0]  id_regA, id_regB, ex_write_reg;
    logic        id_useA, id_useB, id_mult, id_jump_or_branch, ex_mem_read;
    logic        lock_if, lock_id, lock_ex, bubble_ex, bubble_mem, squash_id;
    logic [1:0]  state;
    logic [15:0] stall_cycles;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: mode 0=RUN 1=MULT 2=FLUSH, mult_left = MULT cycles still to go.
    int m_state = 0;
    int m_left  = 0;
    int m_stall = 0;

    pipeline_ctrl #(.MULT_LAT(ML)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_regA(id_regA), .id_regB(id_regB),
        .id_useA(id_useA), .id_useB(id_useB),
        .id_mult(id_mult), .id_jump_or_branch(id_jump_or_branch),
        .ex_write_reg(ex_write_reg), .ex_mem_read(ex_mem_read),
        .lock_if(lock_if), .lock_id(lock_id), .lock_ex(lock_ex),
        .bubble_ex(bubble_ex), .bubble_mem(bubble_mem), .squash_id(squash_id),
        .state(state), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        id_regA = 0; id_regB = 0; id_useA = 0; id_useB = 0;
        id_mult = 0; id_jump_or_branch = 0; ex_write_reg = 0; ex_mem_read = 0;
    endtask

    // Called at posedge+1: checks outputs mid-cycle, advances one edge, updates model.
    task automatic cycle(input string tag);
        bit hz, e_lock, e_mult, e_sq;
        #3;
        hz = (m_state == 0) && ex_mem_read && (ex_write_reg != 0) &&
             ((id_useA && id_regA == ex_write_reg) || (id_useB && id_regB == ex_write_reg));
        e_mult = (m_state == 1);
        e_lock = hz || e_mult;
        e_sq   = (m_state == 2);
        chk({tag, ".lock_if"},    32'(lock_if),      32'(e_lock));
        chk({tag, ".lock_id"},    32'(lock_id),      32'(e_lock));
        chk({tag, ".lock_ex"},    32'(lock_ex),      32'(e_mult));
        chk({tag, ".bubble_ex"},  32'(bubble_ex),    32'(hz));
        chk({tag, ".bubble_mem"}, 32'(bubble_mem),   32'(e_mult));
        chk({tag, ".squash_id"},  32'(squash_id),    32'(e_sq));
        chk({tag, ".state"},      32'(state),        32'(m_state));
        chk({tag, ".stall"},      32'(stall_cycles), 32'(m_stall));
        @(posedge clk);
        if (e_lock && m_stall < 65535) m_stall++;
        case (m_state)
            0: if (!hz) begin
                   if (MULT_EN && id_mult) begin m_state = 1; m_left = ML - 1; end
                   else if (id_jump_or_branch) m_state = 2;
               end
            1: begin m_left--; if (m_left == 0) m_state = 0; end
            default: m_state = 0;
        endcase
        #1;
    endtask

    // Called at posedge+1: asynchronous reset, checked before and after an edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #2;
        chk({tag, ".rst.state"}, 32'(state), 32'd0);
        chk({tag, ".rst.stall"}, 32'(stall_cycles), 32'd0);
        chk({tag, ".rst.outs"},  32'({lock_if, lock_id, lock_ex, bubble_ex, bubble_mem, squash_id}), 32'd0);
        @(posedge clk); #1;
        chk({tag, ".rst.hold"},  32'({state, lock_if, lock_id, lock_ex, bubble_ex, bubble_mem, squash_id}), 32'd0);
        m_state = 0; m_left = 0; m_stall = 0;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        // Hazard pattern on inputs during reset must not reach the outputs.
        ex_mem_read = 1; ex_write_reg = 5; id_useA = 1; id_regA = 5;
        do_reset("reset");
        idle_inputs();
        cycle("idle");

        // No stall on r0
        ex_mem_read = 1; ex_write_reg = 0; id_useA = 1; id_regA = 0;
        cycle("r0");
        idle_inputs();
        cycle("r0_after");

        // Load-use via A, then via B
        ex_mem_read = 1; ex_write_reg = 5; id_useA = 1; id_regA = 5;
        cycle("loaduse_a");
        idle_inputs();
        cycle("loaduse_a_after");
        ex_mem_read = 1; ex_write_reg = 9; id_useB = 1; id_regB = 9; id_regA = 9;
        cycle("loaduse_b");
        idle_inputs();
        ex_mem_read = 1; ex_write_reg = 9; id_useA = 0; id_regA = 9;
        cycle("useA_off");
        idle_inputs();

        // Branch
        id_jump_or_branch = 1;
        cycle("branch");
        id_jump_or_branch = 0;
        cycle("flush");
        cycle("flush_after");

        // Priority: load-use with branch, then branch alone once EX moves on
        ex_mem_read = 1; ex_write_reg = 3; id_useA = 1; id_regA = 3; id_jump_or_branch = 1;
        cycle("prio_stall");
        ex_mem_read = 0;
        cycle("prio_branch");
        idle_inputs();
        cycle("prio_flush");
        cycle("prio_done");

        // Multiply pulse, with a load-use pattern arriving mid-operation
        id_mult = 1;
        cycle("mult_start");
        id_mult = 0;
        ex_mem_read = 1; ex_write_reg = 7; id_useA = 1; id_regA = 7;
        cycle("mult_1");
        idle_inputs();
        for (int i = 0; i < ML; i++) cycle("mult_n");

        // Reset at the second MULT cycle
        id_mult = 1;
        cycle("mult2_start");
        id_mult = 0;
        cycle("mult2_1");
        do_reset("mult_abort");
        cycle("post_abort");

        // Random traffic with occasional reset
        for (int n = 0; n < 800; n++) begin
            id_regA = 5'($urandom_range(0, 3));
            id_regB = 5'($urandom_range(0, 3));
            ex_write_reg = 5'($urandom_range(0, 3));
            id_useA = 1'($urandom_range(0, 1));
            id_useB = 1'($urandom_range(0, 1));
            ex_mem_read = 1'($urandom_range(0, 1));
            id_mult = ($urandom_range(0, 7) == 0);
            id_jump_or_branch = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 199) == 0) do_reset("rand");
            else cycle("rand");
        end

        // Saturation of the stall counter under a permanent hazard
        idle_inputs();
        do_reset("sat");
        ex_mem_read = 1; ex_write_reg = 2; id_useB = 1; id_regB = 2;
        repeat (65540) @(posedge clk);
        #1;
        m_stall = 65535;
        chk("sat.value", 32'(stall_cycles), 32'hFFFF);
        cycle("sat_hold");
        idle_inputs();
        cycle("sat_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
